// File: rtl/pipe_sched_pkg.sv
// Shared constants and ID helpers for the pipe_sched scheduler and its arbiter.
// Later shared-resource blocks reuse the same ID encoding.
package pipe_sched_pkg;

    localparam int N_DEF      = 10;
    localparam int LAT_DEF    = 3;
    localparam int MAXOUT_DEF = 2;
    localparam int NREQ       = 2;
    localparam int IDW        = 1;

    localparam logic [IDW-1:0] ID_REQ0 = 1'b0;
    localparam logic [IDW-1:0] ID_REQ1 = 1'b1;

    function automatic logic [NREQ-1:0] id_to_onehot(input logic [IDW-1:0] id);
        return (id == ID_REQ1) ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [IDW-1:0] onehot_to_id(input logic [NREQ-1:0] oh);
        return oh[1] ? ID_REQ1 : ID_REQ0;
    endfunction

endpackage

// File: rtl/pipe_sched_rr_arb2.sv
// Two-way round-robin arbiter: a lone eligible requester wins, a tie goes to
// the requester not granted last. The pointer only moves on an actual grant.
module rr_arb2
    import pipe_sched_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] elig_i,
    output logic [1:0] grant_o
);

    logic last_q;
    logic last_d;

    always_comb begin
        grant_o = 2'b00;
        last_d  = last_q;
        case (elig_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = (last_q == ID_REQ1) ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
        endcase
        if (|grant_o) begin
            last_d = onehot_to_id(grant_o);
        end
    end

    // Reset as if req1 was granted last so req0 takes the first tie.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= ID_REQ1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/pipe_sched.sv
// Shares one external LAT-cycle datapath between two requesters: arbitrates,
// muxes operands, tracks owner IDs alongside the datapath and routes results back.
module pipe_sched
    import pipe_sched_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int LAT    = LAT_DEF,
    parameter int MAXOUT = MAXOUT_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic [NREQ-1:0]   req_valid_i,
    output logic [NREQ-1:0]   req_ready_o,
    input  logic [NREQ*N-1:0] req_a_i,
    input  logic [NREQ*N-1:0] req_b_i,
    input  logic [NREQ*N-1:0] req_c_i,
    input  logic [NREQ*N-1:0] req_d_i,
    output logic [N-1:0]      dp_a_o,
    output logic [N-1:0]      dp_b_o,
    output logic [N-1:0]      dp_c_o,
    output logic [N-1:0]      dp_d_o,
    output logic              dp_issue_o,
    input  logic [N-1:0]      dp_f_i,
    output logic [NREQ-1:0]   resp_valid_o,
    output logic [N-1:0]      resp_data_o,
    output logic              busy_o
);

    localparam int CNTW  = $clog2(MAXOUT + 1);
    // Stage 0 mirrors the datapath operand register; the tail lines up with dp_f.
    localparam int DEPTH = LAT + 1;

    logic [DEPTH-1:0]           sh_vld_q, sh_vld_d;
    logic [DEPTH-1:0][IDW-1:0]  sh_id_q,  sh_id_d;
    logic [NREQ-1:0][CNTW-1:0]  cnt_q,    cnt_d;
    logic [NREQ-1:0]            resp_valid_q, resp_valid_d;
    logic [N-1:0]               resp_data_q,  resp_data_d;

    logic [NREQ-1:0] retire_oh;
    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] grant;
    logic            issue;

    assign retire_oh = sh_vld_q[DEPTH-1] ? id_to_onehot(sh_id_q[DEPTH-1]) : '0;

    // A slot retiring on this edge is counted as free so a capped requester
    // can re-issue back-to-back with its oldest op completing.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NREQ; i++) begin
            elig[i] = req_valid_i[i] & en_i & ~rst_i &
                      ((int'(cnt_q[i]) - int'(retire_oh[i])) < MAXOUT);
        end
    end

    rr_arb2 u_arb (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .elig_i  (elig),
        .grant_o (grant)
    );

    assign issue       = |grant;
    assign req_ready_o = grant;
    assign dp_issue_o  = issue;

    always_comb begin
        dp_a_o = '0;
        dp_b_o = '0;
        dp_c_o = '0;
        dp_d_o = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                dp_a_o = req_a_i[i*N +: N];
                dp_b_o = req_b_i[i*N +: N];
                dp_c_o = req_c_i[i*N +: N];
                dp_d_o = req_d_i[i*N +: N];
            end
        end
    end

    always_comb begin
        sh_vld_d = {sh_vld_q[DEPTH-2:0], issue};
        sh_id_d  = {sh_id_q[DEPTH-2:0], onehot_to_id(grant)};
    end

    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i] && !retire_oh[i]) begin
                cnt_d[i] = cnt_q[i] + CNTW'(1);
            end else if (!grant[i] && retire_oh[i]) begin
                cnt_d[i] = cnt_q[i] - CNTW'(1);
            end
        end
    end

    always_comb begin
        resp_valid_d = retire_oh;
        resp_data_d  = sh_vld_q[DEPTH-1] ? dp_f_i : resp_data_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sh_vld_q     <= '0;
            sh_id_q      <= '0;
            cnt_q        <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
        end else begin
            sh_vld_q     <= sh_vld_d;
            sh_id_q      <= sh_id_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end

    assign resp_valid_o = resp_valid_q;
    assign resp_data_o  = resp_data_q;
    assign busy_o       = (|sh_vld_q) | (|resp_valid_q);

endmodule
